// File: rtl/serial_cmd_pkg.sv
// Shared types and field widths for the serial command parser.
package serial_cmd_pkg;
    localparam int CMD_READ_BIT = 7;
    localparam int ADDR_W       = 6;
    localparam int LEN_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GETLEN,
        ST_WRDATA,
        ST_RDFETCH,
        ST_RDCAPT,
        ST_RDSEND,
        ST_RDGAP
    } state_t;
endpackage

// File: rtl/serial_cmd_parser_if.sv
// Byte FIFO handshake plus register-bus signals between parser and its environment.
interface serial_cmd_parser_if;
    import serial_cmd_pkg::*;

    logic              cmdfifo_rxf;
    logic [7:0]        cmdfifo_din;
    logic              cmdfifo_rd;
    logic              cmdfifo_txe;
    logic              cmdfifo_wr;
    logic [7:0]        cmdfifo_dout;
    logic [ADDR_W-1:0] reg_addr;
    logic [LEN_W-1:0]  reg_bytecnt;
    logic [7:0]        reg_datao;
    logic              reg_write;
    logic              reg_read;
    logic [7:0]        reg_datai;

    modport master (
        input  cmdfifo_rxf, cmdfifo_din, cmdfifo_txe, reg_datai,
        output cmdfifo_rd, cmdfifo_wr, cmdfifo_dout,
               reg_addr, reg_bytecnt, reg_datao, reg_write, reg_read
    );

    modport slave (
        output cmdfifo_rxf, cmdfifo_din, cmdfifo_txe, reg_datai,
        input  cmdfifo_rd, cmdfifo_wr, cmdfifo_dout,
               reg_addr, reg_bytecnt, reg_datao, reg_write, reg_read
    );
endinterface

// File: rtl/serial_cmd_timeout.sv
// Inter-byte idle counter: clear has priority, terminal count pulses on the last allowed cycle.
module serial_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // A byte arriving in the terminal cycle clears the count, so it suppresses the abort.
    assign o_tc = i_en && !i_clr && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/serial_cmd_parser.sv
// Parses command/length/data packets from a byte FIFO into register writes, or
// streams register reads back out through the transmit FIFO.
module serial_cmd_parser
    import serial_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk_i,
    input  logic                reset_i,
    serial_cmd_parser_if.master bus,
    output logic                busy_o,
    output logic                overrun_o,
    output logic                timeout_o
);
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_flag;
    logic [LEN_W-1:0]  r_len, r_bytecnt, w_wr_idx;
    logic [7:0]        r_datao, r_dout;
    logic              r_write, r_overrun;
    logic              w_accept, w_rd_state, w_tc, w_wr_last, w_rd_last;

    assign w_accept   = bus.cmdfifo_rxf && reset_i &&
                        (r_state inside {ST_IDLE, ST_GETLEN, ST_WRDATA});
    assign w_rd_state = r_state inside {ST_RDFETCH, ST_RDCAPT, ST_RDSEND, ST_RDGAP};
    // A write still in flight has not bumped bytecnt yet; count it so back-to-back bytes end on time.
    assign w_wr_idx   = r_bytecnt + LEN_W'(r_write);
    assign w_wr_last  = (w_wr_idx == r_len - LEN_W'(1));
    assign w_rd_last  = (r_bytecnt == r_len - LEN_W'(1));

    serial_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_clr   (w_accept || (r_state == ST_IDLE)),
        .i_en    (r_state inside {ST_GETLEN, ST_WRDATA}),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_next = ST_GETLEN;
            ST_GETLEN: begin
                if (w_accept) begin
                    if (bus.cmdfifo_din == 8'd0) w_next = ST_IDLE;
                    else if (r_rd_flag)          w_next = ST_RDFETCH;
                    else                         w_next = ST_WRDATA;
                end else if (w_tc) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WRDATA: begin
                if (w_accept) begin
                    if (w_wr_last) w_next = ST_IDLE;
                end else if (w_tc) begin
                    w_next = ST_IDLE;
                end
            end
            ST_RDFETCH: w_next = ST_RDCAPT;
            ST_RDCAPT:  w_next = ST_RDSEND;
            ST_RDSEND:  if (bus.cmdfifo_txe) w_next = ST_RDGAP;
            ST_RDGAP:   w_next = w_rd_last ? ST_IDLE : ST_RDFETCH;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmdfifo_rd = w_accept;
        bus.reg_read   = (r_state == ST_RDFETCH);
        bus.cmdfifo_wr = (r_state == ST_RDSEND) && bus.cmdfifo_txe;
        timeout_o      = w_tc;
        busy_o         = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_addr    <= '0;
            r_rd_flag <= 1'b0;
            r_len     <= '0;
            r_bytecnt <= '0;
            r_datao   <= '0;
            r_write   <= 1'b0;
            r_dout    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_write <= 1'b0;
            if (r_write) r_bytecnt <= r_bytecnt + LEN_W'(1);
            if (bus.cmdfifo_rxf && w_rd_state) r_overrun <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_addr    <= bus.cmdfifo_din[ADDR_W-1:0];
                    r_rd_flag <= bus.cmdfifo_din[CMD_READ_BIT];
                end
                ST_GETLEN: if (w_accept) begin
                    r_len     <= bus.cmdfifo_din;
                    r_bytecnt <= '0;
                end
                ST_WRDATA: if (w_accept) begin
                    r_datao <= bus.cmdfifo_din;
                    r_write <= 1'b1;
                end
                ST_RDCAPT: r_dout <= bus.reg_datai;
                ST_RDGAP:  if (!w_rd_last) r_bytecnt <= r_bytecnt + LEN_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.reg_addr     = r_addr;
    assign bus.reg_bytecnt  = r_bytecnt;
    assign bus.reg_datao    = r_datao;
    assign bus.reg_write    = r_write;
    assign bus.cmdfifo_dout = r_dout;
    assign overrun_o        = r_overrun;
endmodule

// File: tb/tb_serial_cmd_parser.sv
// Randomized bench for serial_cmd_parser with a transaction-level expectation model.
module tb_serial_cmd_parser;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, ovr, tmo;

    serial_cmd_parser_if bus();

    serial_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i     (clk),
        .reset_i   (rst_n),
        .bus       (bus),
        .busy_o    (busy),
        .overrun_o (ovr),
        .timeout_o (tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a;
        logic [7:0] i;
        logic [7:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] tq[$];
    wr_t        me;

    int tests = 0, fails = 0;
    int n_rd = 0, exp_rd = 0, n_wr = 0, n_tmo = 0, n_write = 0;
    int w0, r0, t0, k;
    bit txe_rand = 1'b0;
    logic txe_force = 1'b1;
    bit prev_wr = 1'b0;
    bit pend = 1'b0;
    logic [7:0] pv;
    bit p_rd;
    logic [5:0] p_a;
    int p_l, p_gap;
    logic [7:0] p_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Register file contents as seen by reads; address 3 holds 0x10 + index.
    function automatic logic [7:0] rdat(input logic [5:0] a, input logic [7:0] i);
        if (a == 6'd3) return 8'h10 + i;
        return {a[3:0], a[5:2]} ^ (i * 8'd29) ^ 8'hA5;
    endfunction

    // Read data is driven only for the cycle after reg_read; garbage otherwise.
    initial begin
        bus.reg_datai = 8'h00;
        forever begin
            @(negedge clk);
            if (pend) begin
                bus.reg_datai = pv;
                pend = 1'b0;
            end else begin
                bus.reg_datai = 8'($urandom);
            end
            if (bus.reg_read) begin
                pend = 1'b1;
                pv = rdat(bus.reg_addr, bus.reg_bytecnt);
            end
        end
    end

    initial begin
        bus.cmdfifo_txe = 1'b1;
        forever begin
            @(negedge clk);
            bus.cmdfifo_txe = txe_rand ? 1'($urandom) : txe_force;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (bus.cmdfifo_rd) n_rd++;
                if (tmo) n_tmo++;
                if (bus.reg_write) begin
                    n_write++;
                    if (wq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_reg_write: addr=0x%0h cnt=%0d data=0x%0h, expected no write",
                                 bus.reg_addr, bus.reg_bytecnt, bus.reg_datao);
                    end else begin
                        me = wq.pop_front();
                        chk("reg_write_addr", bus.reg_addr, me.a);
                        chk("reg_write_bytecnt", bus.reg_bytecnt, me.i);
                        chk("reg_write_data", bus.reg_datao, me.d);
                    end
                end
                if (bus.cmdfifo_wr) begin
                    n_wr++;
                    chk("wr_spacing_prev", prev_wr, 0);
                    if (tq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_tx: byte=0x%0h, expected no transmit", bus.cmdfifo_dout);
                    end else begin
                        chk("tx_byte", bus.cmdfifo_dout, tq.pop_front());
                    end
                end
                prev_wr = bus.cmdfifo_wr;
            end else begin
                prev_wr = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic send(input logic [7:0] b);
        bus.cmdfifo_rxf = 1'b1;
        bus.cmdfifo_din = b;
        exp_rd++;
        @(negedge clk);
        bus.cmdfifo_rxf = 1'b0;
    endtask

    task automatic send_drop(input logic [7:0] b);
        bus.cmdfifo_rxf = 1'b1;
        bus.cmdfifo_din = b;
        @(negedge clk);
        bus.cmdfifo_rxf = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int c = 0;
        while ((busy || wq.size() != 0 || tq.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (c >= budget) begin
            fails++;
            $display("FAIL %s: busy=%0d wq=%0d tq=%0d after %0d cycles, required idle and drained",
                     nm, busy, wq.size(), tq.size(), c);
        end
        idle(2);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_overrun"}, ovr, 0);
        chk({nm, "_timeout"}, tmo, 0);
        chk({nm, "_rd"}, bus.cmdfifo_rd, 0);
        chk({nm, "_wr"}, bus.cmdfifo_wr, 0);
        chk({nm, "_reg_write"}, bus.reg_write, 0);
        chk({nm, "_reg_read"}, bus.reg_read, 0);
        chk({nm, "_addr"}, bus.reg_addr, 0);
        chk({nm, "_bytecnt"}, bus.reg_bytecnt, 0);
        chk({nm, "_datao"}, bus.reg_datao, 0);
        chk({nm, "_dout"}, bus.cmdfifo_dout, 0);
    endtask

    initial begin
        bus.cmdfifo_rxf = 1'b0;
        bus.cmdfifo_din = 8'h00;
        rst_n = 1'b0;
        idle(3);
        check_reset("reset");
        rst_n = 1'b1;
        idle(2);

        // Literal write packet.
        wq.push_back('{6'd5, 8'd0, 8'hAA});
        wq.push_back('{6'd5, 8'd1, 8'h55});
        send(8'h05); send(8'h02); send(8'hAA); idle(1); send(8'h55);
        wait_done("wr_literal", 50);
        chk("wr_literal_busy", busy, 0);
        chk("wr_literal_count", n_write, 2);

        // Literal read packet, txe held high.
        txe_force = 1'b1;
        w0 = n_wr;
        tq.push_back(8'h10); tq.push_back(8'h11); tq.push_back(8'h12);
        send(8'h83); send(8'h03);
        wait_done("rd_literal", 100);
        chk("rd_literal_wr_count", n_wr - w0, 3);

        // Backpressure.
        txe_force = 1'b0;
        idle(1);
        w0 = n_wr;
        tq.push_back(rdat(6'd1, 8'd0));
        send(8'h81); send(8'h01);
        idle(50);
        chk("bp_no_wr", n_wr - w0, 0);
        chk("bp_busy_held", busy, 1);
        txe_force = 1'b1;
        wait_done("bp_release", 50);
        chk("bp_one_wr", n_wr - w0, 1);

        // Timeout after a lone command byte.
        t0 = n_tmo;
        w0 = n_write;
        send(8'h01);
        k = 1;
        while (!tmo && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_cycle", k, TMO);
        idle(1);
        chk("tmo_back_idle", busy, 0);
        chk("tmo_pulse_count", n_tmo - t0, 1);
        chk("tmo_no_write", n_write - w0, 0);
        wq.push_back('{6'd1, 8'd0, 8'h7E});
        send(8'h01); send(8'h01); send(8'h7E);
        wait_done("tmo_recover", 50);
        chk("tmo_recover_no_abort", n_tmo - t0, 1);

        // Byte landing on the terminal-count cycle wins.
        t0 = n_tmo;
        wq.push_back('{6'd2, 8'd0, 8'h5A});
        send(8'h02);
        idle(TMO - 1);
        send(8'h01);
        send(8'h5A);
        wait_done("coinc", 50);
        chk("coinc_no_tmo", n_tmo - t0, 0);

        // Overrun while stalled in the send state.
        chk("ovr_before", ovr, 0);
        txe_force = 1'b0;
        idle(1);
        tq.push_back(rdat(6'd9, 8'd0));
        tq.push_back(rdat(6'd9, 8'd1));
        send(8'h89); send(8'h02);
        idle(5);
        r0 = n_rd;
        send_drop(8'hEE);
        idle(1);
        chk("ovr_no_rd", n_rd - r0, 0);
        chk("ovr_set", ovr, 1);
        txe_force = 1'b1;
        wait_done("ovr_resp", 100);
        chk("ovr_sticky", ovr, 1);

        // Reset in the middle of a write packet.
        wq.push_back('{6'd10, 8'd0, 8'h11});
        send(8'h0A); send(8'h04); send(8'h11);
        idle(2);
        chk("mid_first_write_seen", wq.size(), 0);
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        idle(2);
        rst_n = 1'b1;
        w0 = n_write;
        idle(6);
        chk("mid_no_partial_write", n_write - w0, 0);
        chk("mid_idle", busy, 0);
        wq.push_back('{6'd10, 8'd0, 8'h22});
        wq.push_back('{6'd10, 8'd1, 8'h33});
        send(8'h0A); send(8'h02); send(8'h22); send(8'h33);
        wait_done("mid_new_pkt", 50);

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            p_rd = 1'($urandom_range(0, 1));
            p_a = 6'($urandom);
            p_l = $urandom_range(0, 6);
            txe_rand = p_rd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (p_rd) begin
                for (int i = 0; i < p_l; i++) tq.push_back(rdat(p_a, 8'(i)));
            end
            send({p_rd, 1'($urandom), p_a});
            idle($urandom_range(0, 3));
            send(8'(p_l));
            if (!p_rd) begin
                for (int i = 0; i < p_l; i++) begin
                    p_d = 8'($urandom);
                    wq.push_back('{p_a, 8'(i), p_d});
                    p_gap = $urandom_range(0, 3);
                    idle(p_gap);
                    send(p_d);
                end
            end
            wait_done("rand_pkt", 400);
            txe_rand = 1'b0;
        end

        idle(3);
        chk("rd_pulse_count", n_rd, exp_rd);
        chk("queues_drained", wq.size() + tq.size(), 0);
        chk("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_cmd_parser.md
SERIAL_CMD_PARSER -- requirements
Module: serial_cmd_parser

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes of one packet before abort.
REQ-002 Port: clk_i  in  1  sole clock; all state on rising edge.
REQ-003 Port: reset_i  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: cmdfifo_rxf  in  1  one-cycle pulse, received byte valid on cmdfifo_din.
REQ-005 Port: cmdfifo_din  in  8  received byte.
REQ-006 Port: cmdfifo_rd  out  1  one-cycle pulse in the cycle a received byte is consumed.
REQ-007 Port: cmdfifo_txe  in  1  high = transmitter can accept a byte.
REQ-008 Port: cmdfifo_wr  out  1  one-cycle transmit strobe.
REQ-009 Port: cmdfifo_dout  out  8  byte to transmit, valid while cmdfifo_wr high.
REQ-010 Port: reg_addr  out  6  register address of current packet.
REQ-011 Port: reg_bytecnt  out  8  byte index within current packet.
REQ-012 Port: reg_datao  out  8  write data.
REQ-013 Port: reg_write  out  1  one-cycle register write strobe.
REQ-014 Port: reg_read  out  1  one-cycle register read strobe.
REQ-015 Port: reg_datai  in  8  read data, valid exactly one cycle after reg_read.
REQ-016 Port: busy_o  out  1  high whenever state is not IDLE.
REQ-017 Port: overrun_o  out  1  sticky; byte arrived while in a read state.
REQ-018 Port: timeout_o  out  1  one-cycle pulse on packet abort by timeout.

Function
REQ-019 Packet: byte0 command (bit7=1 read, 0 write; bit6 ignored; bits5:0 address); byte1 length L; then L data bytes (write only).
REQ-020 States: IDLE, GETLEN, WRDATA, RDFETCH, RDCAPT, RDSEND, RDGAP.
REQ-021 Every cmdfifo_rxf pulse in IDLE, GETLEN, WRDATA is consumed: cmdfifo_rd asserts that same cycle.
REQ-022 IDLE + rxf: latch reg_addr=din[5:0], read flag=din[7], -> GETLEN.
REQ-023 GETLEN + rxf: latch L, reg_bytecnt=0; L=0 -> IDLE; else write -> WRDATA, read -> RDFETCH.
REQ-024 WRDATA + rxf: next cycle reg_datao=din, reg_write=1 for one cycle at current reg_bytecnt; then bytecnt+1; after L-th write -> IDLE.
REQ-025 RDFETCH: reg_read=1 one cycle -> RDCAPT; RDCAPT captures reg_datai -> RDSEND.
REQ-026 RDSEND: when cmdfifo_txe=1, cmdfifo_wr=1 one cycle with captured byte -> RDGAP; txe=0 holds.
REQ-027 RDGAP: one mandatory idle cycle; then bytecnt+1 and RDFETCH, or IDLE after L-th byte.
REQ-028 cmdfifo_wr never asserts on two consecutive cycles.
REQ-029 rxf pulse in any read state: byte dropped, cmdfifo_rd stays 0, overrun_o set; cleared only by reset.
REQ-030 Timeout counter: cleared on every consumed byte and in IDLE; counts in GETLEN and WRDATA; reaching TIMEOUT_CYCLES -> IDLE, timeout_o pulse; no reg_write issued.
REQ-031 rxf coincident with timeout terminal count: byte wins, counter clears, no abort.
REQ-032 reg_bytecnt arithmetic 8-bit; L max 255, no wrap within packet.

Reset
REQ-033 reset_i low: state IDLE, all strobes 0, reg_addr/reg_bytecnt/reg_datao/cmdfifo_dout 0, busy_o 0, overrun_o 0, timeout counter 0.
REQ-034 Reset mid-packet aborts immediately; no partial strobe after release.

Structure
REQ-035 Shared package serial_cmd_pkg holds state enum, CMD_READ_BIT=7, ADDR_W=6, LEN_W=8.
REQ-036 One sub-module: serial_cmd_timeout (load-clear counter, terminal-count pulse).

Verification
REQ-037 Write: rx 0x05,0x02,0xAA,0x55 -> two reg_write pulses addr=5, bytecnt 0/1, data 0xAA/0x55; busy_o low after.
REQ-038 Read: rx 0x83,0x03, reg_datai=0x10+bytecnt, txe always 1 -> cmdfifo_wr bytes 0x10,0x11,0x12, each wr separated by >=1 idle cycle.
REQ-039 Backpressure: read L=1 with txe=0 for 50 cycles -> no cmdfifo_wr until txe=1, then exactly one.
REQ-040 Timeout: TIMEOUT_CYCLES=100, rx 0x01 then silence -> timeout_o at cycle 100, IDLE; next 0x01,0x01,0x7E -> one write 0x7E.
REQ-041 Overrun: rxf pulse during RDSEND -> overrun_o=1, no cmdfifo_rd, read response unaffected.
REQ-042 Reset asserted in WRDATA after 1 of 4 bytes -> all outputs reset values; new packet after release parsed correctly.
